// File: rtl/shadow_register_bank_pkg.sv
// Shared types and helpers for the shadow register bank.
package shadow_reg_pkg;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } commit_state_e;

    // Channel-select width: enough bits to address n channels, never less than one.
    function automatic int ch_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shadow_register_bank_if.sv
// Config-side write/commit bus and status/data returned by the shadow register bank.
interface shadow_register_bank_if #(
    parameter int WIDTH  = 4,
    parameter int NUM_CH = 4
);
    import shadow_reg_pkg::*;

    localparam int CH_W = ch_w(NUM_CH);

    logic                    sync_clr;
    logic                    wr_en;
    logic [CH_W-1:0]         wr_ch;
    logic [WIDTH-1:0]        wr_data;
    logic [WIDTH-1:0]        wr_mask;
    logic                    commit;
    logic                    commit_busy;
    logic                    commit_ack;
    logic [NUM_CH-1:0]       dirty;
    logic                    wr_err;
    logic [NUM_CH*WIDTH-1:0] data_out;

    modport master (
        output sync_clr, wr_en, wr_ch, wr_data, wr_mask, commit,
        input  commit_busy, commit_ack, dirty, wr_err, data_out
    );

    modport slave (
        input  sync_clr, wr_en, wr_ch, wr_data, wr_mask, commit,
        output commit_busy, commit_ack, dirty, wr_err, data_out
    );

endinterface

// File: rtl/shadow_register_bank_lane.sv
// One channel: staging (shadow) register, output (active) register and dirty flag.
module shadow_lane_reg #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_wr_hit,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [WIDTH-1:0] i_wr_mask,
    input  logic             i_xfer,
    output logic [WIDTH-1:0] o_active,
    output logic             o_dirty
);

    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_active;
    logic             r_dirty;

    // Shadow register: merge masked write data; only bits with mask=1 change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow <= RESET_VAL;
        end else if (i_clr) begin
            r_shadow <= RESET_VAL;
        end else if (i_wr_hit) begin
            r_shadow <= (r_shadow & ~i_wr_mask) | (i_wr_data & i_wr_mask);
        end else begin
            r_shadow <= r_shadow;
        end
    end

    // Active register: takes the pre-edge shadow value, so a same-edge write waits for the next commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_active <= RESET_VAL;
        end else if (i_clr) begin
            r_active <= RESET_VAL;
        end else if (i_xfer) begin
            r_active <= r_shadow;
        end else begin
            r_active <= r_active;
        end
    end

    // Dirty flag: a write wins over the transfer clear, since that write is not yet active.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dirty <= 1'b0;
        end else if (i_clr) begin
            r_dirty <= 1'b0;
        end else if (i_wr_hit) begin
            r_dirty <= 1'b1;
        end else if (i_xfer) begin
            r_dirty <= 1'b0;
        end else begin
            r_dirty <= r_dirty;
        end
    end

    assign o_active = r_active;
    assign o_dirty  = r_dirty;

endmodule

// File: rtl/shadow_register_bank.sv
// NUM_CH channels of masked shadow registers with an atomic all-channel commit.
module shadow_register_bank
    import shadow_reg_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter int               NUM_CH    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    shadow_register_bank_if.slave bus
);

    localparam int CH_W = ch_w(NUM_CH);

    commit_state_e           r_state;
    commit_state_e           w_state_next;
    logic                    w_xfer;
    logic                    w_ch_ok;
    logic                    w_wr_legal;
    logic                    w_wr_illegal;
    logic [NUM_CH-1:0]       w_wr_hit;
    logic [NUM_CH-1:0]       w_dirty;
    logic [NUM_CH*WIDTH-1:0] w_data;
    logic                    r_ack;
    logic                    r_err;

    // Commit FSM next state; the transfer happens on every edge spent in S_PENDING unless cleared.
    always_comb begin
        w_state_next = r_state;
        w_xfer       = 1'b0;
        if (bus.sync_clr) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_next = bus.commit ? S_PENDING : S_IDLE;
                end
                S_PENDING: begin
                    w_xfer       = 1'b1;
                    w_state_next = bus.commit ? S_PENDING : S_IDLE;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // Channel decode: legal writes hit exactly one lane, out-of-range channels only flag an error.
    always_comb begin
        w_ch_ok      = (32'(bus.wr_ch) < NUM_CH);
        w_wr_legal   = bus.wr_en && !bus.sync_clr && w_ch_ok;
        w_wr_illegal = bus.wr_en && !bus.sync_clr && !w_ch_ok;
        w_wr_hit     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_wr_hit[i] = w_wr_legal && (bus.wr_ch == CH_W'(i));
        end
    end

    // Commit FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Registered one-cycle pulses: ack after each transfer edge, error after an illegal write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_ack <= w_xfer;
            r_err <= w_wr_illegal;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        shadow_lane_reg #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .i_clr     (bus.sync_clr),
            .i_wr_hit  (w_wr_hit[g]),
            .i_wr_data (bus.wr_data),
            .i_wr_mask (bus.wr_mask),
            .i_xfer    (w_xfer),
            .o_active  (w_data[g*WIDTH +: WIDTH]),
            .o_dirty   (w_dirty[g])
        );
    end

    assign bus.commit_busy = (r_state == S_PENDING);
    assign bus.commit_ack  = r_ack;
    assign bus.wr_err      = r_err;
    assign bus.dirty       = w_dirty;
    assign bus.data_out    = w_data;

endmodule

// File: tb/tb_shadow_register_bank.sv
// Scoreboarded random + directed bench for shadow_register_bank (4-channel and 3-channel builds).
module tb_shadow_register_bank;
    import shadow_reg_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    shadow_register_bank_if #(.WIDTH(4), .NUM_CH(4)) bus4();
    shadow_register_bank_if #(.WIDTH(4), .NUM_CH(3)) bus3();

    shadow_register_bank #(.WIDTH(4), .NUM_CH(4), .RESET_VAL(4'h0)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    shadow_register_bank #(.WIDTH(4), .NUM_CH(3), .RESET_VAL(4'h0)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model of the 4-channel bank, in terms of the behavioural rules.
    logic [3:0]  m_sh  [4];
    logic [3:0]  m_act [4];
    logic [3:0]  m_dirty;
    bit          m_pend;
    bit          m_ack;
    logic [15:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pack_act();
        return {m_act[3], m_act[2], m_act[1], m_act[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sh[i]  = 4'h0;
            m_act[i] = 4'h0;
        end
        m_dirty = 4'b0000;
        m_pend  = 1'b0;
        m_ack   = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_data_out"}, 32'(bus4.data_out), 32'(pack_act()));
        check({tag, "_dirty"},    32'(bus4.dirty),    32'(m_dirty));
        check({tag, "_busy"},     32'(bus4.commit_busy), 32'(m_pend));
        check({tag, "_ack"},      32'(bus4.commit_ack),  32'(m_ack));
        check({tag, "_wr_err"},   32'(bus4.wr_err),      32'd0);
    endtask

    // One clock on the 4-channel DUT: drive inputs, advance the model at the edge, compare after it.
    task automatic step(input bit clr, input bit wen, input logic [1:0] ch,
                        input logic [3:0] d, input logic [3:0] m, input bit cm, input string tag);
        bus4.sync_clr = clr;
        bus4.wr_en    = wen;
        bus4.wr_ch    = ch;
        bus4.wr_data  = d;
        bus4.wr_mask  = m;
        bus4.commit   = cm;
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else begin
            m_ack = m_pend;
            if (m_pend) begin
                for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
                m_dirty = 4'b0000;
                exp_q.push_back(pack_act());
            end
            if (wen) begin
                m_sh[ch]    = (m_sh[ch] & ~m) | (d & m);
                m_dirty[ch] = 1'b1;
            end
            m_pend = cm;
        end
        #1;
        check_outputs(tag);
    endtask

    // Scoreboard monitor: each ack must match the next expected active snapshot.
    always @(negedge clk) begin
        logic [15:0] exp_v;
        if (reset === 1'b1 && bus4.commit_ack === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL ack_unexpected: got ack with data %h expected no ack", bus4.data_out);
            end else begin
                exp_v = exp_q.pop_front();
                if (bus4.data_out !== exp_v) begin
                    failures++;
                    $display("FAIL ack_data: got %h expected %h at %0t", bus4.data_out, exp_v, $time);
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        reset         = 1'b0;
        bus4.sync_clr = 1'b0; bus4.wr_en = 1'b0; bus4.wr_ch = 2'd0;
        bus4.wr_data  = 4'h0; bus4.wr_mask = 4'h0; bus4.commit = 1'b0;
        bus3.sync_clr = 1'b0; bus3.wr_en = 1'b0; bus3.wr_ch = 2'd0;
        bus3.wr_data  = 4'h0; bus3.wr_mask = 4'h0; bus3.commit = 1'b0;

        // 1. reset then idle
        repeat (2) @(posedge clk);
        #1;
        check_outputs("in_reset");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, "idle");

        // 2. masked writes without commit, then a commit
        step(1'b0, 1'b1, 2'd1, 4'hD, 4'hF, 1'b0, "wr_full");
        step(1'b0, 1'b1, 2'd1, 4'h0, 4'h3, 1'b0, "wr_mask");
        step(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, "commit");
        step(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, "xfer");
        check("masked_result", 32'(bus4.data_out), 32'h00C0);
        step(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, "after_ack");

        // 3. write and commit at the same edge; write at the transfer edge stays staged
        step(1'b0, 1'b1, 2'd2, 4'hA, 4'hF, 1'b1, "wr_commit");
        step(1'b0, 1'b1, 2'd3, 4'h3, 4'hF, 1'b0, "wr_at_xfer");
        check("same_edge_data", 32'(bus4.data_out), 32'h0AC0);
        check("same_edge_dirty", 32'(bus4.dirty), 32'h8);
        step(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, "idle3");

        // 4. back-to-back commits
        step(1'b0, 1'b1, 2'd0, 4'h1, 4'hF, 1'b1, "b2b_0");
        step(1'b0, 1'b1, 2'd0, 4'h2, 4'hF, 1'b1, "b2b_1");
        check("b2b_seq1", 32'(bus4.data_out[3:0]), 32'h1);
        step(1'b0, 1'b1, 2'd0, 4'h3, 4'hF, 1'b1, "b2b_2");
        check("b2b_seq2", 32'(bus4.data_out[3:0]), 32'h2);
        step(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, "b2b_3");
        check("b2b_seq3", 32'(bus4.data_out[3:0]), 32'h3);
        step(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, "b2b_end");

        // 5a. sync_clr aborts a pending transfer
        step(1'b0, 1'b1, 2'd2, 4'h7, 4'hF, 1'b1, "abort_req");
        step(1'b1, 1'b1, 2'd1, 4'h5, 4'hF, 1'b1, "abort_clr");
        check("clr_data_out", 32'(bus4.data_out), 32'h0000);
        step(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, "abort_idle");

        // 5b. async reset mid-cycle aborts a pending transfer
        step(1'b0, 1'b1, 2'd0, 4'h5, 4'hF, 1'b1, "pre_rst");
        step(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, "pre_rst_xfer");
        step(1'b0, 1'b1, 2'd1, 4'h9, 4'hF, 1'b1, "rst_req");
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        check("async_data_out", 32'(bus4.data_out), 32'h0000);
        check_outputs("async_rst");
        @(posedge clk);
        #1;
        check_outputs("async_hold");
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
                 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0), "rand");
        end
        step(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, "drain0");
        step(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, "drain1");
        @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // 6. three-channel build: illegal channel write
        bus3.wr_en = 1'b1; bus3.wr_ch = 2'd3; bus3.wr_data = 4'hF; bus3.wr_mask = 4'hF;
        @(posedge clk);
        #1;
        bus3.wr_en = 1'b0;
        check("ch3_wr_err", 32'(bus3.wr_err), 32'd1);
        check("ch3_dirty", 32'(bus3.dirty), 32'd0);
        @(posedge clk);
        #1;
        check("ch3_wr_err_pulse", 32'(bus3.wr_err), 32'd0);
        bus3.commit = 1'b1;
        @(posedge clk);
        #1;
        bus3.commit = 1'b0;
        @(posedge clk);
        #1;
        check("ch3_ack", 32'(bus3.commit_ack), 32'd1);
        check("ch3_data_out", 32'(bus3.data_out), 32'h000);
        bus3.wr_en = 1'b1; bus3.wr_ch = 2'd2; bus3.commit = 1'b1;
        @(posedge clk);
        #1;
        bus3.wr_en = 1'b0; bus3.commit = 1'b0;
        check("ch3_legal_err", 32'(bus3.wr_err), 32'd0);
        check("ch3_legal_dirty", 32'(bus3.dirty), 32'h4);
        @(posedge clk);
        #1;
        check("ch3_legal_data", 32'(bus3.data_out), 32'hF00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shadow_register_bank.md
Name: shadow_register_bank

Overview:
- Parametrised successor to the single enabled register: NUM_CH independent WIDTH-bit channels, each with a shadow (staging) register and an active (output) register.
- Writes are bit-masked and land in the shadow register only.
- A commit strobe atomically copies all shadows to the active outputs through a two-state FSM, so downstream logic never sees a partially updated configuration.
- Sits between a config/write source and datapath blocks that need glitch-free, simultaneous multi-channel updates.

Parameters:
- WIDTH, 4, bits per channel (>=1).
- NUM_CH, 4, number of channels (>=2).
- RESET_VAL, '0 (WIDTH bits), value loaded into shadow and active on reset or sync_clr.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to clk externally).
- sync_clr  input  1  synchronous clear of all state.
- wr_en  input  1  write strobe.
- wr_ch  input  CH_W = max(1,$clog2(NUM_CH))  target channel.
- wr_data  input  WIDTH  write data.
- wr_mask  input  WIDTH  per-bit write mask; 1 = update that bit.
- commit  input  1  commit request strobe.
- commit_busy  output  1  high while the FSM is in S_PENDING.
- commit_ack  output  1  one-cycle pulse after an active update.
- dirty  output  NUM_CH  per-channel flag: shadow written since last commit.
- wr_err  output  1  one-cycle pulse for a write to an illegal channel.
- data_out  output  NUM_CH*WIDTH  active registers; channel i occupies bits [i*WIDTH +: WIDTH].

Behaviour:
- Reset (reset==0, async): shadow = active = RESET_VAL for all channels, dirty = 0, state = S_IDLE, commit_ack = 0, wr_err = 0.
- Priority at each edge: sync_clr > commit transfer > write.
  - sync_clr gives the same result as reset, applied synchronously.
  - While sync_clr is high, wr_en and commit are ignored.
- Write:
  - Accepted when wr_en=1 and wr_ch < NUM_CH.
  - Update rule: shadow[ch] <= (shadow[ch] & ~wr_mask) | (wr_data & wr_mask).
  - Sets dirty[ch] even when wr_mask==0.
  - The active register is never touched by a write.
- Illegal write: wr_en=1 with wr_ch >= NUM_CH (only possible when NUM_CH is not a power of 2).
  - Ignored; no state change.
  - wr_err = 1 for the following cycle only.
- FSM, states S_IDLE and S_PENDING:
  - S_IDLE, commit=1 at edge k: go to S_PENDING.
  - S_PENDING at edge k+1: active[i] <= shadow[i] for all i, using shadow as it stands after edge k, so a write accepted at edge k is included.
    - Same edge: all dirty bits clear, except a channel written at edge k+1, whose dirty bit stays 1.
    - Next state: S_IDLE if commit=0, S_PENDING if commit=1 (back-to-back commit; another transfer at edge k+2).
  - commit_ack is registered: high for exactly the cycle after each transfer edge. Back-to-back commits give consecutive ack cycles.
- Latency:
  - commit sampled at edge k: data_out changes after edge k+1; commit_ack is high from edge k+1 to k+2.
  - A write needs a commit to become visible; minimum write-to-data_out is 2 edges (write and commit at the same edge k).
- Write at the transfer edge (k+1) lands in shadow after the copy; it is not visible until the next commit.
- Reset or sync_clr while in S_PENDING: the transfer is aborted, state = S_IDLE, no ack.
- No combinational path from any input to any output.

Decomposition:
- Package shadow_reg_pkg:
  - typedef enum logic {S_IDLE, S_PENDING} commit_state_e.
  - function ch_w(n) returning max(1,$clog2(n)).
- One sub-module, shadow_lane_reg (one channel), instantiated NUM_CH times by generate:
  - Holds shadow, active and dirty.
  - Inputs: wr_hit, wr_data, wr_mask, xfer, clr.
- The FSM, the ack/err registers and the channel decode stay in the top module.

Test Plan (WIDTH=4, NUM_CH=4 unless noted):
1. Reset then idle: reset low 2 cycles, release -> data_out=16'h0000, dirty=0, commit_busy=0, commit_ack=0; held 5 cycles.
2. Masked write, no commit: write ch1 data=4'hD mask=4'hF, then ch1 data=4'h0 mask=4'h3 -> data_out stays 0, dirty=4'b0010. Then commit -> after 2 edges data_out=16'h00C0, commit_ack pulses once, dirty=0.
3. Write and commit at the same edge: ch2 data=4'hA with commit=1 -> data_out[11:8]=4'hA after edge k+1. Next write ch3=4'h3 at edge k+1 -> dirty=4'b1000, data_out[15:12] still 0.
4. Back-to-back commits: commit held 3 cycles with ch0 writes 4'h1,4'h2,4'h3 at edges k, k+1, k+2 -> commit_busy stays high; commit_ack high 3 consecutive cycles; data_out[3:0] sequence 1,2,3.
5. Abort cases:
   - commit at edge k, sync_clr at edge k+1 -> all outputs = RESET_VAL, no ack.
   - Same with async reset asserted mid-cycle -> outputs clear immediately, without waiting for a clock edge.
6. NUM_CH=3: write wr_ch=2'd3 data=4'hF -> wr_err pulses 1 cycle, dirty=0, and a subsequent commit leaves data_out=12'h000.
